// File: rtl/vending_machine.sv
// Vending controller: admin path registers items and prices, user path takes coins,
// vends from a 16-entry item table and returns change. Exposes its state number for debug.
module vending_machine #(
    parameter logic [3:0] ADMIN_PSWRD = 4'd0,
    parameter int         BAL_W       = 6
) (
    input  logic       clk,
    input  logic       res,
    input  logic       mode,
    input  logic       ent,
    input  logic [0:3] pswrd,
    input  logic [0:2] mon,
    input  logic [0:3] it_no,
    input  logic       rem,
    input  logic       add_mon,
    output logic       err_pswrd,
    output logic       err_it_no,
    output logic       suc_it_no,
    output logic       suc_rem,
    output logic [0:4] state,
    output logic [0:9] all_led
);

    typedef enum logic [4:0] {
        S_IDLE       = 5'd0,
        S_MODE       = 5'd1,
        S_PWD_IN     = 5'd2,
        S_PWD_CHK    = 5'd3,
        S_ITEM_IN    = 5'd4,
        S_ITEM_CHK   = 5'd5,
        S_ITEM_DUP   = 5'd6,
        S_PRICE_IN   = 5'd7,
        S_ITEM_ADD   = 5'd8,
        S_USER       = 5'd9,
        S_ADD_MON    = 5'd10,
        S_SEL_IN     = 5'd11,
        S_SEL_CHK    = 5'd12,
        S_BAL_CHK    = 5'd13,
        S_VENDED     = 5'd14,
        S_CHANGE_Q   = 5'd15,
        S_CHANGE_OUT = 5'd16
    } state_t;

    state_t           cur, nxt;
    logic             ent_d, add_d, ent_p, add_p, flag_clr;
    logic [3:0]       pswrd_l, it_no_l;
    logic [2:0]       price_l;
    logic [BAL_W-1:0] balance;
    logic [BAL_W:0]   bal_sum;
    logic             tbl_valid [0:15];
    logic [2:0]       tbl_price [0:15];
    logic             sel_valid;
    logic [2:0]       sel_price;
    logic             set_err_pswrd, set_err_it_no, set_suc_it_no, set_suc_rem;
    logic             lat_pswrd, lat_it, lat_price, tbl_wr, bal_add, bal_sub, bal_clr;

    assign sel_valid = tbl_valid[it_no_l];
    assign sel_price = tbl_price[it_no_l];
    assign bal_sum   = {1'b0, balance} + (BAL_W+1)'(mon);
    assign flag_clr  = ent_p | add_p;
    assign state     = cur;

    // Registered rising-edge detectors for the two buttons
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ent_d <= 1'b0;
            add_d <= 1'b0;
            ent_p <= 1'b0;
            add_p <= 1'b0;
        end else begin
            ent_d <= ent;
            add_d <= add_mon;
            ent_p <= ent & ~ent_d;
            add_p <= add_mon & ~add_d;
        end
    end

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state, flag-set and datapath-enable decode
    always_comb begin
        nxt           = cur;
        set_err_pswrd = 1'b0;
        set_err_it_no = 1'b0;
        set_suc_it_no = 1'b0;
        set_suc_rem   = 1'b0;
        lat_pswrd     = 1'b0;
        lat_it        = 1'b0;
        lat_price     = 1'b0;
        tbl_wr        = 1'b0;
        bal_add       = 1'b0;
        bal_sub       = 1'b0;
        bal_clr       = 1'b0;
        case (cur)
            S_IDLE:     if (ent_p) nxt = S_MODE; else nxt = cur;
            S_MODE: begin
                if (ent_p) nxt = mode ? S_PWD_IN : S_USER;
                else       nxt = cur;
            end
            S_PWD_IN: begin
                if (ent_p) begin lat_pswrd = 1'b1; nxt = S_PWD_CHK; end
                else       nxt = cur;
            end
            S_PWD_CHK: begin
                if (pswrd_l == ADMIN_PSWRD) nxt = S_ITEM_IN;
                else begin set_err_pswrd = 1'b1; nxt = S_PWD_IN; end
            end
            S_ITEM_IN: begin
                if (ent_p) begin lat_it = 1'b1; nxt = S_ITEM_CHK; end
                else       nxt = cur;
            end
            S_ITEM_CHK: begin
                if (sel_valid) begin set_err_it_no = 1'b1; nxt = S_ITEM_DUP; end
                else           nxt = S_PRICE_IN;
            end
            S_ITEM_DUP: nxt = S_IDLE;
            S_PRICE_IN: begin
                if (ent_p) begin lat_price = 1'b1; nxt = S_ITEM_ADD; end
                else       nxt = cur;
            end
            S_ITEM_ADD: begin
                tbl_wr        = 1'b1;
                set_suc_it_no = 1'b1;
                nxt           = S_IDLE;
            end
            // Coin insertion wins over enter when both pulse together
            S_USER: begin
                if (add_p)      nxt = S_ADD_MON;
                else if (ent_p) nxt = S_SEL_IN;
                else            nxt = cur;
            end
            S_ADD_MON: begin bal_add = 1'b1; nxt = S_USER; end
            S_SEL_IN: begin
                if (ent_p) begin lat_it = 1'b1; nxt = S_SEL_CHK; end
                else       nxt = cur;
            end
            S_SEL_CHK: begin
                if (sel_valid) nxt = S_BAL_CHK;
                else begin set_err_it_no = 1'b1; nxt = S_SEL_IN; end
            end
            S_BAL_CHK: begin
                if (balance >= BAL_W'(sel_price)) begin
                    bal_sub       = 1'b1;
                    set_suc_it_no = 1'b1;
                    nxt           = S_VENDED;
                end else begin
                    nxt = S_USER;
                end
            end
            S_VENDED:   if (ent_p) nxt = S_CHANGE_Q; else nxt = cur;
            S_CHANGE_Q: begin
                if (ent_p) nxt = rem ? S_CHANGE_OUT : S_USER;
                else       nxt = cur;
            end
            S_CHANGE_OUT: begin bal_clr = 1'b1; set_suc_rem = 1'b1; nxt = S_IDLE; end
            default:    nxt = S_IDLE;
        endcase
    end

    // Input latches, item table, balance and balance thermometer
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pswrd_l <= 4'd0;
            it_no_l <= 4'd0;
            price_l <= 3'd0;
            balance <= '0;
            all_led <= 10'd0;
            for (int i = 0; i < 16; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_price[i] <= 3'd0;
            end
            tbl_valid[0] <= 1'b1;
            tbl_price[0] <= 3'd1;
            tbl_valid[1] <= 1'b1;
            tbl_price[1] <= 3'd2;
        end else begin
            if (lat_pswrd) pswrd_l <= pswrd;
            if (lat_it)    it_no_l <= it_no;
            if (lat_price) price_l <= mon;
            if (tbl_wr) begin
                tbl_valid[it_no_l] <= 1'b1;
                tbl_price[it_no_l] <= price_l;
            end
            if (bal_clr)      balance <= '0;
            else if (bal_add) balance <= bal_sum[BAL_W] ? {BAL_W{1'b1}} : bal_sum[BAL_W-1:0];
            else if (bal_sub) balance <= balance - BAL_W'(sel_price);
            for (int i = 0; i < 10; i++) begin
                all_led[i] <= (32'(balance) > 32'(i));
            end
        end
    end

    // Sticky status flags; a set in the same cycle as a clear takes precedence
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            err_pswrd <= 1'b0;
            err_it_no <= 1'b0;
            suc_it_no <= 1'b0;
            suc_rem   <= 1'b0;
        end else begin
            err_pswrd <= set_err_pswrd | (err_pswrd & ~flag_clr);
            err_it_no <= set_err_it_no | (err_it_no & ~flag_clr);
            suc_it_no <= set_suc_it_no | (suc_it_no & ~flag_clr);
            suc_rem   <= set_suc_rem   | (suc_rem   & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: expected values go into a scoreboard queue as
// stimulus is applied and are popped when the corresponding DUT output is sampled.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       res, mode, ent, rem, add_mon;
    logic [0:3] pswrd, it_no;
    logic [0:2] mon;
    logic       err_pswrd, err_it_no, suc_it_no, suc_rem;
    logic [0:4] st;
    logic [0:9] all_led;

    vending_machine #(.ADMIN_PSWRD(4'd0), .BAL_W(6)) dut (
        .clk(clk), .res(res), .mode(mode), .ent(ent), .pswrd(pswrd), .mon(mon),
        .it_no(it_no), .rem(rem), .add_mon(add_mon), .err_pswrd(err_pswrd),
        .err_it_no(err_it_no), .suc_it_no(suc_it_no), .suc_rem(suc_rem),
        .state(st), .all_led(all_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === 32'(e.val)) passed++;
            else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic flag(input string tag, input int exp, input logic [31:0] obs);
        push(tag, exp);
        check(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ent_step(input int exp_st);
        push("state_after_ent", exp_st);
        ent = 1'b1;
        tick();
        ent = 1'b0;
        tick();
        check(32'(st));
    endtask

    task automatic add_step(input int exp_st);
        push("state_after_add", exp_st);
        add_mon = 1'b1;
        tick();
        add_mon = 1'b0;
        tick();
        check(32'(st));
    endtask

    task automatic tick_step(input int exp_st);
        push("state_after_tick", exp_st);
        tick();
        check(32'(st));
    endtask

    initial begin
        res = 1'b1; mode = 1'b0; ent = 1'b0; rem = 1'b0; add_mon = 1'b0;
        pswrd = 4'd0; it_no = 4'd0; mon = 3'd0;
        tick();
        tick();
        flag("reset_state", 0, 32'(st));
        flag("reset_led", 0, 32'(all_led));
        flag("reset_flags", 0, 32'({err_pswrd, err_it_no, suc_it_no, suc_rem}));
        flag("reset_balance", 0, 32'(dut.balance));
        res = 1'b0;
        tick();

        // Holding ent yields one transition only
        ent = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        flag("hold_ent_state", 1, 32'(st));
        ent = 1'b0;
        tick();

        // Admin add of item 2 at price 2
        mode = 1'b1;
        ent_step(2);
        pswrd = 4'd0;
        ent_step(3);
        tick_step(4);
        it_no = 4'd2;
        ent_step(5);
        tick_step(7);
        mon = 3'd2;
        ent_step(8);
        tick_step(0);
        flag("add_suc_it_no", 1, 32'(suc_it_no));
        flag("tbl_valid2", 1, 32'(dut.tbl_valid[2]));
        flag("tbl_price2", 2, 32'(dut.tbl_price[2]));

        // Wrong password
        ent_step(1);
        flag("suc_cleared_by_ent", 0, 32'(suc_it_no));
        ent_step(2);
        pswrd = 4'd1;
        ent_step(3);
        tick_step(2);
        flag("err_pswrd_set", 1, 32'(err_pswrd));
        pswrd = 4'd0;
        ent_step(3);
        flag("err_pswrd_cleared", 0, 32'(err_pswrd));
        tick_step(4);

        // Duplicate item
        it_no = 4'd0;
        ent_step(5);
        tick_step(6);
        flag("dup_err_it_no", 1, 32'(err_it_no));
        tick_step(0);
        flag("dup_err_sticky", 1, 32'(err_it_no));
        flag("tbl_price0_kept", 1, 32'(dut.tbl_price[0]));

        // User buy of item 2 with balance 5
        mode = 1'b0;
        ent_step(1);
        ent_step(9);
        mon = 3'd2;
        add_step(10);
        tick_step(9);
        flag("balance_2", 2, 32'(dut.balance));
        mon = 3'd3;
        add_step(10);
        tick_step(9);
        flag("balance_5", 5, 32'(dut.balance));
        ent_step(11);
        it_no = 4'd2;
        ent_step(12);
        tick_step(13);
        tick_step(14);
        flag("vend_suc_it_no", 1, 32'(suc_it_no));
        flag("balance_3", 3, 32'(dut.balance));
        tick();
        flag("led_balance_3", 10'b1110000000, 32'(all_led));
        rem = 1'b1;
        ent_step(15);
        ent_step(16);
        tick_step(0);
        flag("suc_rem", 1, 32'(suc_rem));
        flag("balance_cleared", 0, 32'(dut.balance));
        tick();
        flag("led_cleared", 0, 32'(all_led));

        // Error paths: unknown item, insufficient balance, no change
        ent_step(1);
        ent_step(9);
        ent_step(11);
        it_no = 4'd5;
        ent_step(12);
        tick_step(11);
        flag("unknown_err_it_no", 1, 32'(err_it_no));
        it_no = 4'd2;
        ent_step(12);
        flag("err_it_no_cleared", 0, 32'(err_it_no));
        tick_step(13);
        tick_step(9);
        mon = 3'd1;
        add_step(10);
        tick_step(9);
        ent_step(11);
        ent_step(12);
        tick_step(13);
        tick_step(9);
        flag("short_balance_kept", 1, 32'(dut.balance));
        flag("short_no_suc", 0, 32'(suc_it_no));
        mon = 3'd4;
        add_step(10);
        tick_step(9);
        ent_step(11);
        it_no = 4'd0;
        ent_step(12);
        tick_step(13);
        tick_step(14);
        flag("balance_4", 4, 32'(dut.balance));
        rem = 1'b0;
        ent_step(15);
        ent_step(9);
        flag("no_change_balance_kept", 4, 32'(dut.balance));

        // add_mon and ent together: coin path wins
        mon = 3'd7;
        push("add_priority_state", 10);
        ent = 1'b1;
        add_mon = 1'b1;
        tick();
        ent = 1'b0;
        add_mon = 1'b0;
        tick();
        check(32'(st));
        tick_step(9);
        flag("balance_11", 11, 32'(dut.balance));

        // Saturation
        for (int i = 0; i < 10; i++) begin
            add_step(10);
            tick_step(9);
        end
        flag("balance_saturated", 63, 32'(dut.balance));
        tick();
        flag("led_all_on", 10'b1111111111, 32'(all_led));

        // Asynchronous reset in the user path
        res = 1'b1;
        #1;
        flag("async_reset_state", 0, 32'(st));
        flag("async_reset_balance", 0, 32'(dut.balance));
        flag("async_reset_led", 0, 32'(all_led));
        flag("reset_tbl_valid2", 0, 32'(dut.tbl_valid[2]));
        tick();
        res = 1'b0;
        tick();

        // Reset while a price entry is pending discards the table write
        mode = 1'b1;
        ent_step(1);
        ent_step(2);
        pswrd = 4'd0;
        ent_step(3);
        tick_step(4);
        it_no = 4'd3;
        ent_step(5);
        tick_step(7);
        mon = 3'd5;
        ent = 1'b1;
        tick();
        ent = 1'b0;
        res = 1'b1;
        #1;
        flag("reset_in_7_state", 0, 32'(st));
        tick();
        res = 1'b0;
        tick();
        tick();
        flag("reset_in_7_stays_idle", 0, 32'(st));
        flag("reset_in_7_tbl_valid3", 0, 32'(dut.tbl_valid[3]));
        flag("reset_in_7_tbl_price0", 1, 32'(dut.tbl_price[0]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
# vending_machine

Single-clock FSM vending controller with an admin path (password, register new item number and price) and a user path (insert money, select item, vend, return change). It sits between the front-panel switches/buttons and the status LEDs/7-segment driver. It holds a 16-entry item table and a coin balance, and exposes its 5-bit state number for debug display.

## Interface
- ADMIN_PSWRD, default 4'd0: admin password.
- BAL_W, default 6: balance register width.
- clk  in  1  system clock; all logic on rising edge.
- res  in  1  reset, asynchronous, active-high.
- mode  in  1  path select in state 1: 1 = admin, 0 = user.
- ent  in  1  enter button; rising-edge detected internally.
- pswrd  in  [0:3]  admin password; bit 0 is the MSB (all vectors are MSB-at-index-0).
- mon  in  [0:3-1]  money amount or price, 0..7.
- it_no  in  [0:3]  item number, 0..15.
- rem  in  1  change request, sampled in state 15.
- add_mon  in  1  add-money button; rising-edge detected.
- err_pswrd  out  1  wrong password flag.
- err_it_no  out  1  item-number error flag: duplicate in admin path, unknown in user path.
- suc_it_no  out  1  item successfully added, or item vended.
- suc_rem  out  1  change returned.
- state  out  [0:4]  current state number, 0..16.
- all_led  out  [0:9]  balance thermometer: LED i lit iff balance > i.

## Operation
- Pulses: ent_p and add_mon_p are single-cycle pulses from registered rising-edge detect. Holding a button high never repeats the pulse.
- Item table: 16 entries indexed directly by item number. Each entry has a valid bit and a 3-bit price.
- Table reset: entry 0 valid with price 1, entry 1 valid with price 2, all others invalid.
- States and transitions (unlisted conditions hold the state):
  - 0 IDLE: ent_p -> 1.
  - 1 MODE: ent_p -> 2 if mode=1, else -> 9.
  - 2 PWD_IN: ent_p -> latch pswrd, -> 3.
  - 3 PWD_CHK: latched password equals ADMIN_PSWRD -> 4; otherwise set err_pswrd, -> 2.
  - 4 ITEM_IN: ent_p -> latch it_no, -> 5.
  - 5 ITEM_CHK: entry valid -> set err_it_no, -> 6; otherwise -> 7.
  - 6 ITEM_DUP: -> 0.
  - 7 PRICE_IN: ent_p -> latch mon as price, -> 8.
  - 8 ITEM_ADD: write entry (valid=1, price), set suc_it_no, -> 0. The balance is not touched.
  - 9 USER: add_mon_p -> 10 (takes priority over ent_p in the same cycle); else ent_p -> 11.
  - 10 ADD_MON: balance += mon, saturating at 2^BAL_W-1; -> 9.
  - 11 SEL_IN: ent_p -> latch it_no, -> 12.
  - 12 SEL_CHK: entry invalid -> set err_it_no, -> 11; valid -> 13.
  - 13 BAL_CHK: balance >= price -> balance -= price, set suc_it_no, -> 14; otherwise -> 9, balance unchanged.
  - 14 VENDED: ent_p -> 15.
  - 15 CHANGE_Q: ent_p with rem=1 -> 16; ent_p with rem=0 -> 9, balance kept.
  - 16 CHANGE_OUT: balance := 0, set suc_rem, -> 0.
- State numbers 17..31 are illegal and go to 0 on the next clock.
- Status flags (err_pswrd, err_it_no, suc_it_no, suc_rem):
  - Registered and sticky.
  - All four clear on any ent_p, or on add_mon_p.
  - When a set and a clear occur in the same cycle, the set wins.
- The balance persists across admin sessions. Only res, or state 16, clears it.

## Timing
- Reset (async, res=1): state=0; balance=0; all flags=0; all_led=0; table restored to its reset contents; edge-detect registers and latches cleared.
- Button-driven transitions: one clock after the edge is detected. Button-to-state-change latency is 2 clocks from the input rising edge (1 to register, 1 for the transition).
- States 3, 5, 6, 8, 10, 12, 13 and 16 are transient: each lasts exactly one clock.
- Outputs are registered. state and flags change on the same clock edge as the transition. all_led reflects the balance one clock after the balance updates.
- Reset asserted mid-operation aborts immediately. A table write in progress in state 8 is discarded.

## Test plan
- Admin add: pulse ent (mode=1) twice, pswrd=0 + ent, it_no=2 + ent, mon=2 + ent -> states 0,1,2,3,4,5,7,8,0; suc_it_no=1; entry 2 is valid with price 2.
- Wrong password: pswrd=1 + ent in state 2 -> state 3 then 2; err_pswrd=1; the next ent clears the flag.
- Duplicate item: admin path with it_no=0 -> 5,6,0; err_it_no=1; entry 0 price stays 1.
- User buy: mode=0 + ent, add_mon with mon=2 (balance=2) then mon=3 (balance=5), ent, it_no=2 + ent -> 11,12,13,14; balance=3; all_led=1110000000; ent with rem=1 -> 15,16,0; suc_rem=1; balance=0.
- Error paths: it_no=5 (invalid) -> 12 then 11 with err_it_no=1; item price 2 with balance 1 -> 13 then 9, balance stays 1; rem=0 at state 15 -> state 9, balance kept.
- Saturation and reset: repeated add_mon with mon=7 eleven times -> balance=63, all_led all ones; assert res in state 7 -> state=0, balance=0, entry 2 invalid.
